// File: rtl/row_bias_pkg.sv
// Shared types and helpers for the per-row bias table responder.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

package row_bias_pkg;

  localparam int unsigned GRID_LEN = `GRID_LEN;
  localparam int unsigned IDX_W    = (GRID_LEN > 1) ? $clog2(GRID_LEN) : 1;

  // One-hot shuffle states, same encoding style as the tile FSM.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_PICK = 4'b0010,
    ST_SWAP = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

  // True when exactly one bit of a request index is set.
  function automatic logic is_onehot(input logic [GRID_LEN:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int k = 0; k <= int'(GRID_LEN); k++) begin
      if (v[k]) cnt++;
    end
    return (cnt == 1);
  endfunction

  // Binary position of the set bit in a non-terminal one-hot index.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [GRID_LEN-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < int'(GRID_LEN); k++) begin
      if (v[k]) idx = idx | IDX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/row_bias_lfsr.sv
// Galois LFSR with seed load, single-step advance and zero-seed substitution.
module row_bias_lfsr #(
  parameter int unsigned               LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0]     LFSR_TAPS  = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0]     RESET_SEED = 16'hACE1,
  parameter int unsigned               OUT_W      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] load_value,
  input  logic                  advance,
  output logic [OUT_W-1:0]      rnd
);

  logic [LFSR_WIDTH-1:0] lfsr_q;

  // A zero state would lock up the register, so it is replaced by the reset seed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr_q <= RESET_SEED;
    end else if (load) begin
      lfsr_q <= (load_value == '0) ? RESET_SEED : load_value;
    end else if (advance) begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end
  end

  assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/row_bias_mem.sv
// Per-row bias table: answers tile requests and reshuffles via Fisher-Yates.
module row_bias_mem
  import row_bias_pkg::*;
#(
  parameter int unsigned           LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] RESET_SEED = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rq_rowbias,
  input  logic [GRID_LEN:0]     rq_index,
  output logic [GRID_LEN:0]     value_test,
  output logic                  rq_error,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_value,
  input  logic                  shuffle_start,
  output logic                  shuffle_busy,
  output logic                  shuffle_done
);

  state_e               state, state_nxt;
  logic [IDX_W-1:0]     i_q, j_q, pick_j;
  logic [GRID_LEN-1:0]  bias [GRID_LEN];
  logic                 pick_ok;
  logic                 seed_ld, lfsr_adv, i_init, i_dec, j_lat, swap_en;
  logic                 req_upd, req_err;
  logic [GRID_LEN:0]    reply;

  row_bias_lfsr #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .LFSR_TAPS  (LFSR_TAPS),
    .RESET_SEED (RESET_SEED),
    .OUT_W      (IDX_W)
  ) u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .load       (seed_ld),
    .load_value (seed_value),
    .advance    (lfsr_adv),
    .rnd        (pick_j)
  );

  assign pick_ok = (pick_j <= i_q);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; PICK rejects draws above i until one lands in range.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (shuffle_start) state_nxt = (GRID_LEN > 1) ? ST_PICK : ST_DONE;
      ST_PICK: if (pick_ok) state_nxt = ST_SWAP;
      ST_SWAP: state_nxt = (i_q == IDX_W'(1)) ? ST_DONE : ST_PICK;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath controls and request decode for the current state.
  always_comb begin
    seed_ld  = 1'b0;
    lfsr_adv = 1'b0;
    i_init   = 1'b0;
    i_dec    = 1'b0;
    j_lat    = 1'b0;
    swap_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        seed_ld = seed_load;
        i_init  = shuffle_start;
      end
      ST_PICK: begin
        lfsr_adv = 1'b1;
        j_lat    = pick_ok;
      end
      ST_SWAP: begin
        swap_en = 1'b1;
        i_dec   = (i_q != IDX_W'(1));
      end
      default: ;
    endcase
    req_upd = rq_rowbias && (state == ST_IDLE);
    req_err = rq_rowbias && ((state != ST_IDLE) || !is_onehot(rq_index));
    if (!is_onehot(rq_index))  reply = '0;
    else if (rq_index[GRID_LEN]) reply = {1'b1, {GRID_LEN{1'b0}}};
    else reply = {1'b0, bias[onehot_to_idx(rq_index[GRID_LEN-1:0])]};
  end

  // Shuffle cursor i and latched pick j.
  always_ff @(posedge clock) begin
    if (!reset) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      if (i_init)     i_q <= IDX_W'(GRID_LEN - 1);
      else if (i_dec) i_q <= i_q - IDX_W'(1);
      if (j_lat)      j_q <= pick_j;
    end
  end

  // Bias table: identity on reset, pairwise exchange during SWAP.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < int'(GRID_LEN); k++) bias[k] <= GRID_LEN'(1) << k;
    end else if (swap_en) begin
      bias[i_q] <= bias[j_q];
      bias[j_q] <= bias[i_q];
    end
  end

  // Registered outputs; busy/done track the state being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      value_test   <= '0;
      rq_error     <= 1'b0;
      shuffle_busy <= 1'b0;
      shuffle_done <= 1'b0;
    end else begin
      if (req_upd) value_test <= reply;
      rq_error     <= req_err;
      shuffle_busy <= (state_nxt != ST_IDLE);
      shuffle_done <= (state_nxt == ST_DONE);
    end
  end

endmodule
